// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//
// Bridges the MEM-stage load/store request onto a simple req/ack data bus.
// It holds the pipeline with stall while an access is outstanding. It returns
// the raw read word on RD. A bus error or a wait timeout aborts the access.
//
// Bus handshake: bus_req is the valid strobe and bus_ack is the ready/complete
// strobe. Once bus_req rises, bus_addr, bus_be, bus_wdata and bus_we stay
// constant up to and including the cycle in which bus_ack is sampled high.
// bus_req then drops for at least one cycle. bus_err and bus_rdata are only
// meaningful in a cycle where bus_ack is high.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   MemRead, MemWrite   load / store request (both high => store)
//   Addr, byte_en, WD   byte address, lane enables, lane-aligned store data
//   RD                  registered raw read word
//   stall               pipeline hold while the access is outstanding
//   mem_fault           one-cycle pulse on bus error or timeout
//   bus_req, bus_we     request strobe, write qualifier
//   bus_addr            word-aligned address
//   bus_be, bus_wdata   lane enables, store data
//   bus_ack, bus_err    completion, error qualifier
//   bus_rdata           read data
//   state_dbg           current FSM state (0 IDLE, 1 REQ, 2 DONE)
module dmem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [3:0]  byte_en,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    output logic        stall,
    output logic        mem_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] wait_inc;
    logic [31:0]      rd_q, rd_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             we_q, we_d;
    logic             fault_q, fault_d;
    logic             access_present;

    // The byte offset is folded into the lane enables upstream.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^Addr[1:0];

    // A request with no active lanes is a no-op. It never reaches the bus.
    assign access_present = (MemRead || MemWrite) && (byte_en != 4'b0000);
    assign wait_inc       = wait_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        we_d       = we_q;
        fault_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (access_present) begin
                    addr_d     = {Addr[31:2], 2'b00};
                    be_d       = byte_en;
                    wdata_d    = WD;
                    // A store takes priority when both requests are high.
                    we_d       = MemWrite;
                    wait_cnt_d = '0;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_ack) begin
                    // A completion wins over a timeout in the same cycle.
                    if (bus_err) begin
                        rd_d    = 32'h0;
                        fault_d = 1'b1;
                    end else if (!we_q) begin
                        rd_d = bus_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    // The count includes the current cycle. With TIMEOUT=N the
                    // access aborts at the end of the Nth REQ cycle.
                    wait_cnt_d = wait_inc;
                    if (wait_inc == TIMEOUT_CNT) begin
                        rd_d    = 32'h0;
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // The pipeline advances at the end of this cycle.
                // Any request seen now belongs to the finished instruction.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            rd_q       <= 32'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'b0000;
            we_q       <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            fault_q    <= fault_d;
        end
    end

    // bus_req is derived from state. Reset clears it at once, with no wait
    // for a clock edge.
    assign bus_req   = (state_q == ST_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign RD        = rd_q;
    assign mem_fault = fault_q;
    assign state_dbg = state_q;

    // stall is gated by reset because the IDLE term follows live inputs.
    assign stall = !reset &&
                   (((state_q == ST_IDLE) && access_present) || (state_q == ST_REQ));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

    localparam int TB_TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Addr, WD, RD;
    logic [3:0]  byte_en;
    logic        stall, mem_fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        bus_ack, bus_err;
    logic [1:0]  state_dbg;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_rd;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          ack_wait;   // REQ cycles without ack before the ack (>= TIMEOUT: never)
        bit          err;
        logic [31:0] rdata;
        logic [31:0] exp_rd;
        bit          exp_fault;
        bit          exp_we;
        int          exp_stall;
    } vec_t;

    vec_t tbl[11];

    dmem_access_ctrl #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .byte_en   (byte_en),
        .WD        (WD),
        .RD        (RD),
        .stall     (stall),
        .mem_fault (mem_fault),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .bus_rdata (bus_rdata),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [31:0] addr, logic [3:0] be,
                                logic [31:0] wd, int aw, bit err, logic [31:0] rdata,
                                logic [31:0] exp_rd, bit exp_fault, bit exp_we,
                                int exp_stall);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wd = wd;
        v.ack_wait = aw; v.err = err; v.rdata = rdata;
        v.exp_rd = exp_rd; v.exp_fault = exp_fault; v.exp_we = exp_we;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Entered just after a rising edge with the DUT in IDLE. Returns likewise.
    task automatic do_access(input vec_t v);
        bit          present;
        int          stall_cnt;
        logic [31:0] exp_word;
        present   = (v.rd || v.wr) && (v.be != 4'b0000);
        stall_cnt = 0;
        exp_q.push_back(v.exp_rd);

        MemRead = v.rd; MemWrite = v.wr; Addr = v.addr; byte_en = v.be; WD = v.wd;
        bus_ack = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        chk("idle_bus_req", bus_req, 1'b0);
        chk("idle_stall", stall, present);
        if (stall) stall_cnt++;
        @(posedge clk); #1;

        if (present) begin
            for (int n = 0; n < TB_TIMEOUT; n++) begin
                bus_ack   = (n == v.ack_wait);
                bus_err   = v.err && (n == v.ack_wait);
                bus_rdata = v.rdata;
                @(negedge clk);
                chk("req_state", state_dbg, 2'd1);
                chk("req_bus_req", bus_req, 1'b1);
                chk("req_bus_addr", bus_addr, v.addr & ~32'h3);
                chk("req_bus_be", bus_be, v.be);
                chk("req_bus_wdata", bus_wdata, v.wd);
                chk("req_bus_we", bus_we, v.exp_we);
                chk("req_mem_fault", mem_fault, 1'b0);
                if (stall) stall_cnt++;
                @(posedge clk); #1;
                if (n == v.ack_wait) break;
            end
            bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
            @(negedge clk);
            chk("done_state", state_dbg, 2'd2);
            chk("done_bus_req", bus_req, 1'b0);
            chk("done_stall", stall, 1'b0);
            chk("done_mem_fault", mem_fault, v.exp_fault);
            chk("done_rd", RD, v.exp_rd);
            @(posedge clk); #1;
        end

        MemRead = 1'b0; MemWrite = 1'b0;
        exp_word = exp_q.pop_front();
        @(negedge clk);
        chk("after_state", state_dbg, 2'd0);
        chk("after_bus_req", bus_req, 1'b0);
        chk("after_mem_fault", mem_fault, 1'b0);
        chk("after_rd", RD, exp_word);
        chk("stall_cycles", stall_cnt, v.exp_stall);
        @(posedge clk); #1;
    endtask

    // Behavioural expectation for one access, from the access rules alone.
    function automatic vec_t model(vec_t v, inout logic [31:0] cur_rd);
        bit present, timed_out;
        present   = (v.rd || v.wr) && (v.be != 4'b0000);
        timed_out = v.ack_wait >= TB_TIMEOUT;
        v.exp_we    = v.wr;
        v.exp_fault = present && (timed_out || v.err);
        if (present) begin
            if (timed_out || v.err) cur_rd = 32'h0;
            else if (!v.wr)         cur_rd = v.rdata;
        end
        v.exp_rd    = cur_rd;
        v.exp_stall = !present ? 0 : 1 + (timed_out ? TB_TIMEOUT : v.ack_wait + 1);
        return v;
    endfunction

    // ---------------- test ----------------
    initial begin
        vec_t v;
        //            rd wr addr          be      wd            aw err rdata         exp_rd        flt we stl
        tbl[0]  = mk(1, 0, 32'h0000_1006, 4'b1100, 32'h0,       0, 0, 32'hAABB_CCDD, 32'hAABB_CCDD, 0, 0, 2);
        tbl[1]  = mk(0, 1, 32'h0000_2000, 4'b0001, 32'h0000_005A, 3, 0, 32'h1111_1111, 32'hAABB_CCDD, 0, 1, 5);
        tbl[2]  = mk(1, 0, 32'h0000_0010, 4'b1111, 32'h0,       1, 1, 32'h1234_5678, 32'h0,         1, 0, 3);
        tbl[3]  = mk(1, 0, 32'h0000_0020, 4'b0011, 32'h0,       0, 0, 32'h1122_3344, 32'h1122_3344, 0, 0, 2);
        tbl[4]  = mk(1, 0, 32'h0000_0030, 4'b1111, 32'h0,      99, 0, 32'h9999_9999, 32'h0,         1, 0, 5);
        tbl[5]  = mk(1, 0, 32'h0000_2001, 4'b1111, 32'h0,       3, 0, 32'hCAFE_BABE, 32'hCAFE_BABE, 0, 0, 5);
        tbl[6]  = mk(0, 1, 32'h0000_3000, 4'b0000, 32'hFFFF,    0, 0, 32'h0,         32'hCAFE_BABE, 0, 1, 0);
        tbl[7]  = mk(1, 1, 32'h0000_3003, 4'b0011, 32'h0000_BEEF, 0, 0, 32'hDEAD_BEEF, 32'hCAFE_BABE, 0, 1, 2);
        tbl[8]  = mk(0, 1, 32'hFFFF_FFFE, 4'b1000, 32'h7700_0000, 2, 1, 32'h0,       32'h0,         1, 1, 4);
        tbl[9]  = mk(0, 0, 32'h0000_4000, 4'b1111, 32'h0,       0, 0, 32'h0,         32'h0,         0, 0, 0);
        tbl[10] = mk(1, 0, 32'h0000_4004, 4'b1111, 32'h0,       0, 0, 32'h0BAD_F00D, 32'h0BAD_F00D, 0, 0, 2);

        // reset block: reset held with a live request present
        reset = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Addr = 32'h100;
        byte_en = 4'hF; WD = 32'h0; bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'h0;
        #1;
        chk("rst_stall", stall, 1'b0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_rd", RD, 32'h0);
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_mem_fault", mem_fault, 1'b0);
        chk("rst_state", state_dbg, 2'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0; MemRead = 1'b0; byte_en = 4'h0;
        @(posedge clk); #1;

        // directed table
        for (int i = 0; i < 11; i++) do_access(tbl[i]);

        // reset in the second REQ cycle, then a late ack
        MemRead = 1'b1; Addr = 32'h0000_5000; byte_en = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_bus_req", bus_req, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_bus_req", bus_req, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_state", state_dbg, 2'd0);
        chk("mid_rst_rd", RD, 32'h0);
        chk("mid_rst_bus_be", bus_be, 4'h0);
        @(negedge clk);
        reset = 1'b0; MemRead = 1'b0; byte_en = 4'h0;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        @(negedge clk);
        chk("late_ack_state", state_dbg, 2'd0);
        chk("late_ack_bus_req", bus_req, 1'b0);
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_state2", state_dbg, 2'd0);
        chk("late_ack_rd", RD, 32'h0);
        chk("late_ack_fault", mem_fault, 1'b0);
        @(posedge clk); #1;

        // randomized accesses against the reference model
        model_rd = 32'h0;
        for (int i = 0; i < 40; i++) begin
            v.rd       = ($urandom_range(0, 1) == 1);
            v.wr       = ($urandom_range(0, 2) == 0);
            v.addr     = $urandom;
            v.be       = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            v.wd       = $urandom;
            v.ack_wait = $urandom_range(0, TB_TIMEOUT + 1);
            v.err      = ($urandom_range(0, 3) == 0);
            v.rdata    = $urandom;
            v = model(v, model_rd);
            do_access(v);
        end

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
